// File: rtl/maze_vga_pkg.sv
// maze_vga_pkg: default VGA 640x480@60 timing constants and the raster phase encoding.
// Latency: none (constants and types only).
// Backpressure: none.
package maze_vga_pkg;

    // Horizontal timing in pixel ticks.
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;

    // Vertical timing in lines.
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Phase of one raster axis; both axes walk ACTIVE -> FP -> SYNC -> BP.
    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FP     = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BP     = 2'd3
    } phase_t;

endpackage

// File: rtl/pix_tick_div.sv
// pix_tick_div: divides the system clock into a one-Clk pixel-step strobe every CLK_DIV cycles.
// Latency: first strobe CLK_DIV cycles after reset release (with i_En high).
// Backpressure: i_En low freezes the divider and forces o_PixTick low; it resumes where it stopped.
//
// Ports: Clk, Rst (async active-low), i_En (run enable), o_PixTick (pixel-step strobe).
// CLK_DIV must be at least 1.
module pix_tick_div #(
    parameter int CLK_DIV = 2
) (
    input  logic Clk,
    input  logic Rst,
    input  logic i_En,
    output logic o_PixTick
);

    localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          at_last;

    assign cnt_nxt = (cnt == LAST) ? '0 : cnt + 1'b1;

    // at_last mirrors (cnt == LAST) as a flop, so the strobe comes from a register
    // and is still low straight out of reset even when CLK_DIV is 1.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cnt     <= '0;
            at_last <= 1'b0;
        end else if (i_En) begin
            cnt     <= cnt_nxt;
            at_last <= (cnt_nxt == LAST);
        end
    end

    // Gating with i_En keeps the strobe low for every cycle the block is paused,
    // including a pause that starts on a tick cycle; that tick is re-issued on resume.
    assign o_PixTick = at_last & i_En;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster generator (syncs, active flag, X/Y, pixel strobe, end-of-visible-frame pulse).
// Latency: X/Y/syncs/active/fDrawDone update on the edge that consumes o_PixTick, all zero-skew to each other.
// Backpressure: i_En low freezes divider, counters and phase FSMs; o_PixTick and fDrawDone stay low.
//
// Ports: Clk, Rst (async active-low), i_En, o_hSync, o_vSync, o_Active, o_X[9:0], o_Y[9:0],
//        o_PixTick, fDrawDone; with VGA_FRAME_CNT_EN defined also o_FrameCnt[7:0]
//        (frames completed, wraps 255 -> 0). Totals above 1023 are not supported.
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = maze_vga_pkg::H_ACTIVE,
    parameter int H_FP     = maze_vga_pkg::H_FP,
    parameter int H_SYNC   = maze_vga_pkg::H_SYNC,
    parameter int H_BP     = maze_vga_pkg::H_BP,
    parameter int V_ACTIVE = maze_vga_pkg::V_ACTIVE,
    parameter int V_FP     = maze_vga_pkg::V_FP,
    parameter int V_SYNC   = maze_vga_pkg::V_SYNC,
    parameter int V_BP     = maze_vga_pkg::V_BP,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       i_En,
    output logic       o_hSync,
    output logic       o_vSync,
    output logic       o_Active,
    output logic [9:0] o_X,
    output logic [9:0] o_Y,
    output logic       o_PixTick,
    output logic       fDrawDone
`ifdef VGA_FRAME_CNT_EN
  , output logic [7:0] o_FrameCnt
`endif
);

    import maze_vga_pkg::*;

    // Counter values at which each phase begins, plus the last value of each axis.
    localparam logic [9:0] H_FP_AT    = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_AT  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_BP_AT    = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] H_ACT_LAST = 10'(H_ACTIVE - 1);

    localparam logic [9:0] V_FP_AT    = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYNC_AT  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_BP_AT    = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] V_ACT_LAST = 10'(V_ACTIVE - 1);

    phase_t     h_ph;
    phase_t     v_ph;
    phase_t     h_ph_nxt;
    phase_t     v_ph_nxt;
    phase_t     v_ph_after;
    logic [9:0] h_nxt;
    logic [9:0] v_nxt;
    logic       h_wrap;
    logic       v_wrap;
    logic       frame_end;

    pix_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_tick_div (
        .Clk       (Clk),
        .Rst       (Rst),
        .i_En      (i_En),
        .o_PixTick (o_PixTick)
    );

    assign h_wrap = (o_X == H_LAST);
    assign h_nxt  = h_wrap ? 10'd0 : o_X + 10'd1;
    assign v_wrap = (o_Y == V_LAST);
    assign v_nxt  = v_wrap ? 10'd0 : o_Y + 10'd1;

    // Last visible pixel being stepped past: the top may touch maze state from here on.
    assign frame_end = o_PixTick && (o_X == H_ACT_LAST) && (o_Y == V_ACT_LAST);

    // Phase the axes will hold after the coming step; only consumed on a pixel tick
    // (horizontal) or on a line wrap (vertical).
    always_comb begin
        h_ph_nxt = h_ph;
        case (h_ph)
            PH_ACTIVE: if (h_nxt == H_FP_AT)   h_ph_nxt = PH_FP;
            PH_FP:     if (h_nxt == H_SYNC_AT) h_ph_nxt = PH_SYNC;
            PH_SYNC:   if (h_nxt == H_BP_AT)   h_ph_nxt = PH_BP;
            PH_BP:     if (h_wrap)             h_ph_nxt = PH_ACTIVE;
            default:                           h_ph_nxt = PH_ACTIVE;
        endcase
    end

    always_comb begin
        v_ph_nxt = v_ph;
        case (v_ph)
            PH_ACTIVE: if (v_nxt == V_FP_AT)   v_ph_nxt = PH_FP;
            PH_FP:     if (v_nxt == V_SYNC_AT) v_ph_nxt = PH_SYNC;
            PH_SYNC:   if (v_nxt == V_BP_AT)   v_ph_nxt = PH_BP;
            PH_BP:     if (v_wrap)             v_ph_nxt = PH_ACTIVE;
            default:                           v_ph_nxt = PH_ACTIVE;
        endcase
    end

    assign v_ph_after = h_wrap ? v_ph_nxt : v_ph;

    // Outputs are registered from the next-phase values so they land on the
    // same edge as the counters they describe.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            o_X       <= 10'd0;
            o_Y       <= 10'd0;
            h_ph      <= PH_ACTIVE;
            v_ph      <= PH_ACTIVE;
            o_hSync   <= ~SYNC_POL;
            o_vSync   <= ~SYNC_POL;
            o_Active  <= 1'b1;
            fDrawDone <= 1'b0;
        end else begin
            fDrawDone <= frame_end;
            if (o_PixTick) begin
                o_X      <= h_nxt;
                h_ph     <= h_ph_nxt;
                o_hSync  <= (h_ph_nxt == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
                o_Active <= (h_ph_nxt == PH_ACTIVE) && (v_ph_after == PH_ACTIVE);
                if (h_wrap) begin
                    o_Y     <= v_nxt;
                    v_ph    <= v_ph_nxt;
                    o_vSync <= (v_ph_nxt == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
                end
            end
        end
    end

`ifdef VGA_FRAME_CNT_EN
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            o_FrameCnt <= 8'd0;
        end else if (frame_end) begin
            o_FrameCnt <= o_FrameCnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of vga_timing_gen, one default-timing instance and one
// shrunken-timing instance (10x8 raster, active-high syncs) so whole frames fit in a short run.
// Outputs are sampled on the falling edge; inputs are driven on the falling edge.
module tb_vga_timing_gen;

    // Small raster: H 5+1+2+2 = 10, V 4+1+2+1 = 8, two Clk per pixel -> 160 Clk per frame.
    localparam bit S_POL = 1'b1;

    logic       clk = 1'b0;
    logic       rst_s, en_s, rst_d, en_d;
    logic       hs_s, vs_s, act_s, tick_s, done_s;
    logic       hs_d, vs_d, act_d, tick_d, done_d;
    logic [9:0] x_s, y_s, x_d, y_d;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] fcnt_s, fcnt_d;
`endif

    int n_chk;
    int n_err;

    always #10 clk = ~clk;

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(5), .H_FP(1), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(S_POL)
    ) u_small (
`ifdef VGA_FRAME_CNT_EN
        .o_FrameCnt (fcnt_s),
`endif
        .Clk       (clk),
        .Rst       (rst_s),
        .i_En      (en_s),
        .o_hSync   (hs_s),
        .o_vSync   (vs_s),
        .o_Active  (act_s),
        .o_X       (x_s),
        .o_Y       (y_s),
        .o_PixTick (tick_s),
        .fDrawDone (done_s)
    );

    vga_timing_gen u_def (
`ifdef VGA_FRAME_CNT_EN
        .o_FrameCnt (fcnt_d),
`endif
        .Clk       (clk),
        .Rst       (rst_d),
        .i_En      (en_d),
        .o_hSync   (hs_d),
        .o_vSync   (vs_d),
        .o_Active  (act_d),
        .o_X       (x_d),
        .o_Y       (y_d),
        .o_PixTick (tick_d),
        .fDrawDone (done_d)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Wait (bounded) until the small raster shows position (x,y) with the given strobe level.
    task automatic wait_s(input int x, input int y, input int tk, input string tag);
        int n;
        n = 0;
        while (!(int'(x_s) == x && int'(y_s) == y && int'(tick_s) == tk) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_reached"}, int'(n < 1000), 1);
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cyc, first_hs, last_hs, first_y1, x_at_y1;
        int c_hs, c_vs, c_tick, c_act, c_done;
        int bad_act, bad_hs, bad_vs, bad, max_x, max_y;

        n_chk = 0;
        n_err = 0;
        rst_s = 1'b0;
        rst_d = 1'b0;
        en_s  = 1'b1;
        en_d  = 1'b1;
        repeat (3) @(negedge clk);

        // ---- reset values (syncs deasserted: small is active-high, default active-low)
        chk("rst_x",      int'(x_s),    0);
        chk("rst_y",      int'(y_s),    0);
        chk("rst_tick",   int'(tick_s), 0);
        chk("rst_done",   int'(done_s), 0);
        chk("rst_active", int'(act_s),  1);
        chk("rst_hsync",  int'(hs_s),   0);
        chk("rst_vsync",  int'(vs_s),   0);
        chk("rst_hsync_def", int'(hs_d), 1);
        chk("rst_vsync_def", int'(vs_d), 1);
`ifdef VGA_FRAME_CNT_EN
        chk("rst_framecnt", int'(fcnt_s), 0);
`endif

        // ---- default timing: first line after release
        rst_d = 1'b1;
        first_hs = 0; last_hs = 0; c_hs = 0; c_vs = 0; c_tick = 0; c_act = 0;
        first_y1 = 0; x_at_y1 = -1;
        for (int i = 1; i <= 1700; i++) begin
            @(negedge clk);
            if (hs_d == 1'b0) begin
                if (first_hs == 0) first_hs = i;
                last_hs = i;
                c_hs++;
            end
            if (vs_d == 1'b0) c_vs++;
            if (i <= 1600) begin
                if (tick_d) c_tick++;
                if (act_d)  c_act++;
            end
            if (first_y1 == 0 && y_d == 10'd1) begin
                first_y1 = i;
                x_at_y1  = int'(x_d);
            end
        end
        chk("def_tick_per_line",   c_tick,   800);   // every 2nd Clk
        chk("def_hsync_start_clk", first_hs, 1312);  // X=656 after 656 ticks
        chk("def_hsync_width",     c_hs,     192);   // 96 ticks
        chk("def_hsync_contig",    last_hs - first_hs + 1, 192);
        chk("def_line_period",     first_y1, 1600);  // 800 ticks
        chk("def_x_at_new_line",   x_at_y1,  0);
        chk("def_active_clk_line", c_act,    1280);  // 640 ticks x 2 Clk
        chk("def_vsync_line0",     c_vs,     0);
`ifdef VGA_FRAME_CNT_EN
        chk("def_framecnt", int'(fcnt_d), 0);
`endif

        // ---- small raster: first frame after release
        rst_s = 1'b1;
        cyc = 0;
        first_hs = 0;
        while (done_s !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (first_hs == 0 && hs_s == S_POL) first_hs = cyc;
        end
        chk("s_first_done_clk",  cyc,          70);  // (5,3) is tick 35
        chk("s_done_x",          int'(x_s),    5);
        chk("s_done_y",          int'(y_s),    3);
        chk("s_done_active",     int'(act_s),  0);
        chk("s_first_hsync_clk", first_hs,     12);  // X=6 is tick 6

        // ---- one full frame from this pulse to the next
        c_hs = 0; c_vs = 0; c_tick = 0; c_act = 0; c_done = 0;
        bad_act = 0; bad_hs = 0; bad_vs = 0; max_x = 0; max_y = 0;
        for (int i = 1; i <= 160; i++) begin
            @(negedge clk);
            if (done_s)        c_done++;
            if (tick_s)        c_tick++;
            if (act_s)         c_act++;
            if (hs_s == S_POL) c_hs++;
            if (vs_s == S_POL) c_vs++;
            if (act_s != (x_s < 10'd5 && y_s < 10'd4))                bad_act++;
            if ((hs_s == S_POL) != (x_s >= 10'd6 && x_s <= 10'd7))   bad_hs++;
            if ((vs_s == S_POL) != (y_s >= 10'd5 && y_s <= 10'd6))   bad_vs++;
            if (int'(x_s) > max_x) max_x = int'(x_s);
            if (int'(y_s) > max_y) max_y = int'(y_s);
        end
        chk("s_frame_done_again", int'(done_s), 1);
        chk("s_frame_done_count", c_done,  1);
        chk("s_frame_ticks",      c_tick,  80);   // 10 x 8 pixels
        chk("s_frame_active_clk", c_act,   40);   // 5 x 4 pixels x 2 Clk
        chk("s_frame_hsync_clk",  c_hs,    32);   // 2 px x 8 lines x 2 Clk
        chk("s_frame_vsync_clk",  c_vs,    40);   // 2 lines x 10 px x 2 Clk
        chk("s_active_align",     bad_act, 0);
        chk("s_hsync_align",      bad_hs,  0);
        chk("s_vsync_align",      bad_vs,  0);
        chk("s_max_x",            max_x,   9);
        chk("s_max_y",            max_y,   7);

        // ---- freeze on a tick cycle at (2,1)
        wait_s(2, 1, 1, "frz");
        en_s = 1'b0;
        #1;
        chk("frz_tick_low", int'(tick_s), 0);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (x_s != 10'd2 || y_s != 10'd1 || tick_s || done_s) bad++;
        end
        chk("frz_hold", bad, 0);
        en_s = 1'b1;
        #1;
        chk("frz_resume_tick", int'(tick_s), 1);
        chk("frz_resume_x",    int'(x_s),    2);
        @(negedge clk);
        chk("frz_next_x",      int'(x_s),    3);
        chk("frz_next_tick",   int'(tick_s), 0);

        // ---- reset one Clk before the end-of-frame pulse
        wait_s(4, 3, 1, "mid");
        rst_s = 1'b0;
        #1;
        chk("mid_rst_x",      int'(x_s),    0);
        chk("mid_rst_y",      int'(y_s),    0);
        chk("mid_rst_tick",   int'(tick_s), 0);
        chk("mid_rst_active", int'(act_s),  1);
        chk("mid_rst_hsync",  int'(hs_s),   0);
        @(negedge clk);
        chk("mid_no_done",    int'(done_s), 0);
        rst_s = 1'b1;
        cyc = 0;
        c_done = 0;
        while (done_s !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_next_done_clk", cyc, 70);

`ifdef VGA_FRAME_CNT_EN
        // ---- frame counter: 1 after the first frame, wraps after 256 more
        chk("fcnt_first", int'(fcnt_s), 1);
        bad = 0;
        for (int f = 0; f < 256; f++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (done_s !== 1'b1 && cyc < 400);
            if (cyc != 160) bad++;
            if (f == 254) chk("fcnt_wrap_zero", int'(fcnt_s), 0);
        end
        chk("fcnt_frame_periods", bad, 0);
        chk("fcnt_after_257",     int'(fcnt_s), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Produces the VGA raster that the maze top consumes: hSync, vSync, active-video flag and pixel coordinates.
- Produces fDrawDone, a one-Clk pulse at the end of the visible frame; the top uses it to safely update maze and player state.
- Runs from the 50 MHz system clock and steps pixels on an internal pixel-tick enable.

Parameters:
- CLK_DIV, 2: system Clk cycles per pixel tick (2 gives a 25 MHz pixel rate); must be at least 1.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixel ticks.
- H_SYNC, 96: horizontal sync width, in pixel ticks.
- H_BP, 48: horizontal back porch, in pixel ticks.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- SYNC_POL, 0: asserted level of both sync outputs (0 means active-low).

Ports:
- Clk  input  1  system clock, 50 MHz.
- Rst  input  1  asynchronous, active-low reset.
- i_En  input  1  run enable; while low, all counters and outputs hold their current value.
- o_hSync  output  1  horizontal sync.
- o_vSync  output  1  vertical sync.
- o_Active  output  1  high while the current pixel is visible.
- o_X  output  10  pixel column, 0..H_ACTIVE+H_FP+H_SYNC+H_BP-1.
- o_Y  output  10  line number, 0..V total-1.
- o_PixTick  output  1  one-Clk pixel-step strobe.
- fDrawDone  output  1  one-Clk pulse at the end of the visible frame.

Behaviour:
- Clk and reset: single clock domain. Reset is asynchronous, active-low, and released synchronously by the board.
- Reset values:
  - o_X=0, o_Y=0, o_PixTick=0, fDrawDone=0.
  - o_hSync=o_vSync=~SYNC_POL (deasserted).
  - o_Active=1, since position (0,0) is visible.
- Pixel tick: the divider counts 0..CLK_DIV-1. o_PixTick=1 in the Clk cycle where the count equals CLK_DIV-1; the divider then wraps to 0.
- Horizontal counter:
  - Advances only on o_PixTick.
  - Wraps to 0 after H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
- Vertical counter:
  - Advances only when the horizontal counter wraps.
  - Wraps to 0 after V_TOTAL-1, where V_TOTAL = 525.
- Horizontal phase FSM: ACTIVE -> FP -> SYNC -> BP -> ACTIVE, with transitions at the counter boundaries H_ACTIVE, +H_FP, +H_SYNC and H_TOTAL.
- Vertical phase FSM: the same sequence, using the vertical parameters.
- o_hSync = SYNC_POL exactly when the horizontal FSM is in SYNC; o_vSync likewise.
- o_Active = 1 exactly when both FSMs are in ACTIVE.
- Output alignment: all outputs are registered and updated in the same Clk edge as the counters, so o_X, o_Y, o_Active and the syncs are mutually aligned with zero skew.
- fDrawDone:
  - Asserted for exactly one Clk, on the tick that moves the raster from (H_ACTIVE-1, V_ACTIVE-1) to (H_ACTIVE, V_ACTIVE-1).
  - That is once per frame, at the start of vertical blanking.
- i_En low:
  - The divider, both counters and both FSMs freeze.
  - o_PixTick=0 and fDrawDone=0; the other outputs hold.
  - On re-enable, operation resumes from the frozen position with no skipped ticks.
- Reset asserted mid-frame: immediate return to the reset values. The next frame starts at (0,0) with the full sync sequence and no stale fDrawDone.
- Widths: 10-bit counters are sufficient for totals up to 1023. Raising any total above 1023 is unsupported.

Optional Feature:
- Macro: VGA_FRAME_CNT_EN.
- Defined:
  - Adds output o_FrameCnt, 8 bits, reset to 0.
  - Increments in the same cycle fDrawDone pulses and wraps 255 -> 0.
  - Used by the top for blink and timer effects on the FND displays.
- Undefined: the port and counter are absent, and all other behaviour is identical.

Decomposition:
- Shared package maze_vga_pkg holds:
  - The default timing constants H_ACTIVE..V_BP and the derived H_TOTAL and V_TOTAL.
  - The 2-bit phase encoding: ACTIVE=0, FP=1, SYNC=2, BP=3.
- One sub-module, pix_tick_div: the parameterised CLK_DIV divider producing o_PixTick, with enable and asynchronous active-low reset.
- Both phase FSMs stay in vga_timing_gen.

Test Plan:
- Reset release with i_En=1 and default parameters:
  - o_PixTick every 2nd Clk.
  - o_hSync low for 192 Clk, starting 1312 Clk (656 pixel ticks) after X=0.
  - Line period 1600 Clk.
- Frame timing:
  - fDrawDone pulses once per 840000 Clk.
  - Each pulse is 1 Clk wide, coincident with o_X=640 and o_Y=479.
  - o_vSync is low during o_Y=490..491 only.
- o_Active check: high exactly for X<640 and Y<480, giving a count of 307200 active ticks per frame.
- Freeze: drop i_En at X=300, Y=100 for 50 Clk.
  - Outputs hold X=300, Y=100; no ticks and no fDrawDone.
  - After re-enable the next tick gives X=301.
- Reset mid-frame: assert Rst at Y=479, X=639 one Clk before fDrawDone would pulse.
  - No pulse occurs; outputs return to the reset values.
  - The next fDrawDone arrives a full frame later.
- With VGA_FRAME_CNT_EN: run 257 frames; o_FrameCnt reads 1 after the wrap.
